// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequence generator: FSM state encoding,
// feedback mode constants and default maximal-length tap masks per width.
// No logic; imported by lfsr_step and lfsr_seq_gen.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

  // Known-good tap masks for common widths; other widths fall back to the
  // 8-bit mask and should override TAPS explicitly.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      16:      return {16'h0000, TAPS_W16};
      32:      return TAPS_W32;
      default: return {24'h000000, TAPS_W8};
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One LFSR advance, Fibonacci or Galois form.
// Latency: purely combinational. Backpressure: none (caller decides when to load).
// Ports: state (current LFSR value), mode (0=Fibonacci, 1=Galois), next (advanced value).
module lfsr_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_pkg::default_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic [WIDTH-1:0] next
);
  import lfsr_pkg::*;

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;

  always_comb begin
    // Fibonacci: parity of the tapped bits shifts in at the LSB.
    fib_fb   = ^(state & TAPS);
    fib_next = {state[WIDTH-2:0], fib_fb};
    // Galois: shift right, and the bit falling out of the LSB toggles every tap.
    gal_next = (state >> 1) ^ (state[0] ? TAPS : '0);
    next     = (mode == MODE_GAL) ? gal_next : fib_next;
  end

endmodule

// File: rtl/lfsr_seq_gen.sv
// Seeded LFSR generator emitting seq_num values over a valid/ready output.
// Latency: start sampled at an edge -> first value (the seed) valid right after it.
// Backpressure: num and the remaining count hold while num_valid && !num_ready.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, mode          start request (IDLE only), 0=Fibonacci / 1=Galois
//   sw_in, seq_num       seed and value count, captured with start
//   num, num_valid       current value and its valid flag
//   num_ready            consumer accept
//   busy, done           high while running, one-cycle completion pulse
module lfsr_seq_gen #(
  parameter int               WIDTH    = 8,
  parameter int               CNT_W    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_pkg::default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] ZERO_SUB = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [CNT_W-1:0] seq_num,
  output logic [WIDTH-1:0] num,
  output logic             num_valid,
  input  logic             num_ready,
  output logic             busy,
  output logic             done
);
  import lfsr_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] lfsr_adv;
  logic [WIDTH-1:0] seed_eff;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             mode_q, mode_d;
  logic             beat;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .state (lfsr_q),
    .mode  (mode_q),
    .next  (lfsr_adv)
  );

  // An all-zero LFSR is a fixed point, so a zero seed is replaced.
  assign seed_eff = (sw_in == '0) ? ZERO_SUB : sw_in;
  assign beat     = (state_q == ST_RUN) && num_ready;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    remain_d = remain_q;
    mode_d   = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_d   = seed_eff;
          remain_d = seq_num;
          mode_d   = mode;
          // A zero-length request still reports completion, without beats.
          state_d  = (seq_num == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (beat) begin
          lfsr_d   = lfsr_adv;
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= '0;
      remain_q <= '0;
      mode_q   <= MODE_FIB;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      remain_q <= remain_d;
      mode_q   <= mode_d;
    end
  end

  // All outputs come straight from registers, so there is no combinational
  // path from any input to any output.
  assign num       = lfsr_q;
  assign num_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_lfsr_seq_gen.sv
module tb_lfsr_seq_gen;

  localparam int TAPS_M = 184; // 0xB8

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] sw_in;
  logic [7:0] seq_num;
  logic [7:0] num;
  logic       num_valid;
  logic       num_ready;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  int exp_q[$];
  int tab_q[$];

  int done_cnt = 0;
  int beats    = 0;
  int seq_id   = 0;
  int cur_id   = 0;
  int distinct = 0;
  int zero_cnt = 0;
  int busy_cnt = 0;
  int seen_gen [256];

  lfsr_seq_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .sw_in     (sw_in),
    .seq_num   (seq_num),
    .num       (num),
    .num_valid (num_valid),
    .num_ready (num_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: shift register arithmetic on integers.
  function automatic int model_step(input int x, input bit gal);
    int fb;
    fb = 0;
    if (!gal) begin
      for (int i = 0; i < 8; i++)
        if ((((TAPS_M >> i) & 1) == 1) && (((x >> i) & 1) == 1)) fb = fb ^ 1;
      return ((x * 2) + fb) % 256;
    end
    return (x / 2) ^ (((x % 2) == 1) ? TAPS_M : 0);
  endfunction

  // Monitor / scoreboard
  bit       stall_prev = 0;
  bit       last_prev  = 0;
  bit       done_prev  = 0;
  bit       last_now;
  bit [7:0] held_num   = 0;

  always @(negedge clk) begin
    last_now = 0;
    if (cur_id != seq_id) begin
      cur_id   = seq_id;
      distinct = 0;
      zero_cnt = 0;
      busy_cnt = 0;
    end
    if (rst !== 1'b0) begin
      stall_prev = 0;
      last_prev  = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", num_valid, 1);
        chk("hold_num", num, held_num);
      end
      if (last_prev) chk("done_after_last", done, 1);
      if (done) begin
        chk("done_one_cycle", done_prev, 0);
        chk("done_no_valid", num_valid, 0);
        done_cnt++;
      end
      chk("busy_eq_valid", busy, num_valid);
      if (busy) busy_cnt++;
      if (num_valid && num_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", num, 32'hFFFF_FFFF);
        end else begin
          chk("num", num, exp_q.pop_front());
          last_now = (exp_q.size() == 0);
        end
        beats++;
        if (num == 8'h00) zero_cnt++;
        if (seen_gen[num] != seq_id) begin
          seen_gen[num] = seq_id;
          distinct++;
        end
      end
      stall_prev = num_valid && !num_ready;
      held_num   = num;
      last_prev  = last_now;
    end
    done_prev = done;
  end

  task automatic issue_start(input int seed, input int n, input bit md);
    int x;
    seq_id++;
    x = (seed == 0) ? 1 : seed;
    if (tab_q.size() > 0) begin
      foreach (tab_q[i]) exp_q.push_back(tab_q[i]);
      tab_q.delete();
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(x);
        x = model_step(x, md);
      end
    end
    @(posedge clk); #1;
    start   = 1'b1;
    sw_in   = 8'(seed);
    seq_num = 8'(n);
    mode    = md;
    @(posedge clk); #1;
    // Scramble captured inputs; they must have no further effect.
    start   = 1'b0;
    sw_in   = 8'($urandom);
    seq_num = 8'($urandom);
    mode    = 1'($urandom);
  endtask

  task automatic run_seq(input int seed, input int n, input bit md, input int rmode, input bit rstart);
    int d0, b0, stall, cyc;
    d0 = done_cnt;
    b0 = beats;
    num_ready = 1'b1;
    issue_start(seed, n, md);
    if (n == 0) chk("lat_done", done, 1);
    else chk("lat_valid", num_valid, 1);
    stall = 0;
    cyc   = 0;
    while (done_cnt == d0 && cyc < 4000) begin
      case (rmode)
        0: num_ready = 1'b1;
        1: num_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if ((beats - b0) == 1 && stall < 3) begin
            num_ready = 1'b0;
            stall++;
          end else begin
            num_ready = 1'b1;
          end
        end
      endcase
      if (rstart) begin
        start   = ($urandom_range(0, 3) == 0);
        sw_in   = 8'($urandom);
        seq_num = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_timeout", (done_cnt != d0), 1);
    chk("done_cleared", done, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("beat_count", beats - b0, n);
    if (rmode == 0) chk("busy_cycles", busy_cnt, n);
    if (rmode == 2) chk("stall_cycles", stall, 3);
    exp_q.delete();
  endtask

  initial begin
    int d0, b0, cyc;
    rst = 1'b1; start = 1'b1; mode = 1'b0; sw_in = 8'h05; seq_num = 8'h03; num_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_num", num, 0);
    chk("rst_valid", num_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Directed Fibonacci and Galois sequences
    tab_q = '{8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    run_seq(8'h08, 5, 1'b0, 0, 1'b0);
    tab_q = '{8'h08, 8'h04, 8'h02, 8'h01, 8'hB8};
    run_seq(8'h08, 5, 1'b1, 0, 1'b0);
    // Backpressure on the second value
    tab_q = '{8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    run_seq(8'h08, 5, 1'b0, 2, 1'b0);
    // Zero seed substitution and zero-length request
    tab_q = '{8'h01, 8'h02, 8'h04};
    run_seq(8'h00, 3, 1'b0, 0, 1'b0);
    run_seq(8'h22, 0, 1'b0, 0, 1'b0);
    // Full period with ignored start pulses while busy
    run_seq(8'h01, 255, 1'b0, 0, 1'b1);
    chk("period_distinct", distinct, 255);
    chk("period_no_zero", zero_cnt, 0);

    // Reset at the third beat
    d0 = done_cnt;
    b0 = beats;
    num_ready = 1'b1;
    issue_start(8'h08, 5, 1'b0);
    cyc = 0;
    while ((beats - b0) < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_wait_timeout", (beats - b0), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun_num", num, 0);
    chk("midrun_valid", num_valid, 0);
    chk("midrun_busy", busy, 0);
    chk("midrun_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("midrun_no_done", done_cnt, d0);
    chk("midrun_idle", num_valid, 0);
    tab_q = '{8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    run_seq(8'h08, 5, 1'b0, 0, 1'b0);

    // Randomized sequences against the reference model
    for (int k = 0; k < 20; k++) begin
      run_seq($urandom_range(0, 255), $urandom_range(0, 12), 1'($urandom), 1, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
